// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends PATTERN MSB first, rep_cnt times per start pulse.
// Optional feature macro INTERGAP_EN inserts GAP_LEN idle cycles between repetitions.
module seq_pattern_tx #(
  parameter int               PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = 4'b1100,
  parameter int               CNT_W    = 8,
  parameter logic             IDLE_BIT = 1'b0,
  parameter int               GAP_LEN  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rem,
  output logic [1:0]       ps
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  localparam int               IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

  if ((PAT_W < 2) || (GAP_LEN < 1)) begin : g_param_check
    $error("seq_pattern_tx: PAT_W must be >= 2 and GAP_LEN >= 1");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] idx_dec_s;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

`ifdef INTERGAP_EN
  localparam int               GAP_W   = $clog2(GAP_LEN + 1);
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'(GAP_LEN - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`endif

  assign idx_dec_s = idx_q - IDX_W'(1);

  // Next-state and next-output computation; outputs are registered one cycle later.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = 1'b0;
`ifdef INTERGAP_EN
    gap_d   = gap_q;
`endif
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = IDX_TOP;
      rem_d   = {CNT_W{1'b0}};
      out_d   = IDLE_BIT;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort && (rep_cnt != {CNT_W{1'b0}})) begin
            state_d = ST_SEND;
            rem_d   = rep_cnt;
            idx_d   = IDX_TOP;
            out_d   = PATTERN[IDX_TOP];
            valid_d = 1'b1;
          end else begin
            out_d   = IDLE_BIT;
            valid_d = 1'b0;
          end
        end
        ST_SEND: begin
          if (idx_q != {IDX_W{1'b0}}) begin
            idx_d   = idx_dec_s;
            out_d   = PATTERN[idx_dec_s];
            valid_d = 1'b1;
          end else if (rem_q > CNT_W'(1)) begin
            // More repetitions pending: either restart immediately or idle for the gap
            rem_d = rem_q - CNT_W'(1);
            idx_d = IDX_TOP;
`ifdef INTERGAP_EN
            state_d = ST_GAP;
            gap_d   = GAP_TOP;
            out_d   = IDLE_BIT;
            valid_d = 1'b0;
`else
            out_d   = PATTERN[IDX_TOP];
            valid_d = 1'b1;
`endif
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
            rem_d   = {CNT_W{1'b0}};
            idx_d   = IDX_TOP;
            out_d   = IDLE_BIT;
            valid_d = 1'b0;
          end
        end
`ifdef INTERGAP_EN
        ST_GAP: begin
          if (gap_q == {GAP_W{1'b0}}) begin
            state_d = ST_SEND;
            out_d   = PATTERN[IDX_TOP];
            valid_d = 1'b1;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
`endif
        ST_FIN: begin
          state_d = ST_IDLE;
          out_d   = IDLE_BIT;
          valid_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = IDX_TOP;
          rem_d   = {CNT_W{1'b0}};
          out_d   = IDLE_BIT;
          valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_TOP;
      rem_q   <= {CNT_W{1'b0}};
      out_q   <= IDLE_BIT;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef INTERGAP_EN
      gap_q   <= {GAP_W{1'b0}};
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef INTERGAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign rem   = rem_q;
  assign ps    = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected bits/done pulses are queued at stimulus
// time and consumed by a negedge monitor; a 1100 detector model counts pattern hits.
module tb_seq_pattern_tx;

`ifdef INTERGAP_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] rep_cnt;
  logic       out, valid, busy, done;
  logic [7:0] rem;
  logic [1:0] ps;

  int   checks   = 0;
  int   failures = 0;
  bit   exp_q[$];
  int   done_exp = 0;
  int   det_cnt  = 0;
  logic [2:0] det_sh = 3'b000;
  logic [3:0] pat = 4'b1100;

  seq_pattern_tx dut (
    .clk(clk), .reset(reset), .start(start), .rep_cnt(rep_cnt), .abort(abort),
    .out(out), .valid(valid), .busy(busy), .done(done), .rem(rem), .ps(ps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid bit and every done pulse must match a queued expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected_bit actual=%0b expected=none @%0t", out, $time);
      end else begin
        chk("sb_bit", {31'd0, out}, {31'd0, exp_q.pop_front()});
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_exp == 0) begin
        failures++;
        $display("FAIL sb_unexpected_done actual=1 expected=0 @%0t", $time);
      end else begin
        done_exp--;
      end
    end
  end

  // Mealy 1100 detector fed with the valid bit stream.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (det_sh == 3'b110 && out == 1'b0) det_cnt <= det_cnt + 1;
      det_sh <= {det_sh[1:0], out};
    end else begin
      det_sh <= 3'b000;
    end
  end

  task automatic push_bits(input int nbits);
    for (int i = 0; i < nbits; i++) exp_q.push_back(pat[3 - (i % 4)]);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ps"}, {30'd0, ps}, 32'd0);
    chk({tag, "_out"}, {31'd0, out}, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_rem"}, {24'd0, rem}, 32'd0);
  endtask

  task automatic run_xfer(input int n);
    int total, d0;
    total = 4 * n + (n - 1) * GAP;
    push_bits(4 * n);
    done_exp++;
    d0 = det_cnt;
    @(posedge clk); #1 start = 1'b1; rep_cnt = 8'(n);
    @(posedge clk); #1 start = 1'b0; rep_cnt = 8'd0;
    chk("c1_ps", {30'd0, ps}, 32'd1);
    chk("c1_valid", {31'd0, valid}, 32'd1);
    chk("c1_out", {31'd0, out}, 32'd1);
    chk("c1_busy", {31'd0, busy}, 32'd1);
    chk("c1_rem", {24'd0, rem}, 32'(n));
    // start while busy must be ignored
    @(posedge clk); #1 start = 1'b1; rep_cnt = 8'd5;
    @(posedge clk); #1 start = 1'b0; rep_cnt = 8'd0;
    chk("busy_start_rem", {24'd0, rem}, 32'(n));
    chk("busy_start_ps", {30'd0, ps}, 32'd1);
    repeat (total - 2) @(posedge clk);
    #1;
    chk("fin_done", {31'd0, done}, 32'd1);
    chk("fin_ps", {30'd0, ps}, 32'd3);
    chk("fin_valid", {31'd0, valid}, 32'd0);
    chk("fin_rem", {24'd0, rem}, 32'd0);
    start = 1'b1; rep_cnt = 8'd2;
    @(posedge clk); #1 start = 1'b0; rep_cnt = 8'd0;
    check_idle("post_fin");
    @(posedge clk); #1;
    chk("det_hits", 32'(det_cnt - d0), 32'(n));
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; rep_cnt = 8'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_idle("reset");

    run_xfer(1);
    run_xfer(3);
    run_xfer(2);

    // rep_cnt == 0 is ignored
    @(posedge clk); #1 start = 1'b1; rep_cnt = 8'd0;
    @(posedge clk); #1 start = 1'b0;
    check_idle("zero_cnt");

    // abort in IDLE blocks a simultaneous start
    @(posedge clk); #1 start = 1'b1; rep_cnt = 8'd2; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; rep_cnt = 8'd0; abort = 1'b0;
    check_idle("idle_abort");

    // abort on the 2nd bit of the 2nd repetition
    push_bits(6);
    d0 = det_cnt;
    @(posedge clk); #1 start = 1'b1; rep_cnt = 8'd3;
    @(posedge clk); #1 start = 1'b0; rep_cnt = 8'd0;
    repeat (5 + GAP) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check_idle("abort");
    repeat (6) @(posedge clk);
    #1 chk("abort_det_hits", 32'(det_cnt - d0), 32'd1);

    // reset mid-SEND together with start
    push_bits(3);
    @(posedge clk); #1 start = 1'b1; rep_cnt = 8'd2;
    @(posedge clk); #1 start = 1'b0; rep_cnt = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; start = 1'b1; rep_cnt = 8'd2;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0; rep_cnt = 8'd0;
    check_idle("mid_reset");
    repeat (4) @(posedge clk);

    // full-scale count: 255 repetitions, rem never wraps
    run_xfer(255);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_bits_left", 32'(exp_q.size()), 32'd0);
    chk("sb_done_left", 32'(done_exp), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
